// File: rtl/s5_pkg.sv
// Shared constants, state encoding and flag helpers for the stage-5 byte packer.
package s5_pkg;

  localparam int unsigned S5_BYTE_W         = 8;
  localparam int unsigned MAX_BYTES_PER_SET = 5;
  localparam int unsigned S5_LANES          = 2 * MAX_BYTES_PER_SET;
  localparam int unsigned S5_LANE_CNT_W     = 4;
  localparam int unsigned STALL_THRESHOLD   = 10;
  localparam int unsigned S5_COUNT_W        = 32;

  typedef enum logic [1:0] {
    S5_IDLE   = 2'd0,
    S5_STREAM = 2'd1,
    S5_DRAIN  = 2'd2,
    S5_DONE   = 2'd3
  } s5_state_e;

  // Out-of-range byte counts collapse to zero bytes.
  function automatic logic s5_flag_bad(input logic [2:0] flag);
    return flag > 3'(MAX_BYTES_PER_SET);
  endfunction

  function automatic logic [2:0] s5_flag_count(input logic [2:0] flag);
    return s5_flag_bad(flag) ? 3'd0 : flag;
  endfunction

endpackage

// File: rtl/s5_byte_fifo.sv
// Multi-lane-write, single-read fall-through byte FIFO with a per-entry "last" tag.
module s5_byte_fifo
  import s5_pkg::*;
#(
  parameter int unsigned W     = S5_BYTE_W,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [S5_LANES*W-1:0]    wr_data_i,
  input  logic [S5_LANES-1:0]      wr_tag_i,
  input  logic [S5_LANE_CNT_W-1:0] wr_cnt_i,
  input  logic                     tag_prev_i,
  input  logic                     rd_i,
  output logic [W-1:0]             rd_data_o,
  output logic                     rd_tag_o,
  output logic [AW:0]              count_o,
  output logic [AW:0]              count_next_o
);

  localparam int unsigned CW = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] tag_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             rd_en;

  assign rd_en        = rd_i && (count_q != '0);
  assign count_next_o = count_q + CW'(wr_cnt_i) - CW'(rd_en);
  assign count_o      = count_q;
  assign rd_data_o    = mem_q[rd_ptr_q];
  assign rd_tag_o     = tag_q[rd_ptr_q];

  // Data storage carries no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(S5_LANES); k++) begin
      if (k < int'(wr_cnt_i)) begin
        mem_q[wr_ptr_q + AW'(k)] <= wr_data_i[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
    end else begin
      for (int k = 0; k < int'(S5_LANES); k++) begin
        if (k < int'(wr_cnt_i)) begin
          tag_q[wr_ptr_q + AW'(k)] <= wr_tag_i[k];
        end
      end
      // Retro-tag the newest entry when a frame ends on an empty write cycle.
      if (tag_prev_i) begin
        tag_q[wr_ptr_q - AW'(1)] <= 1'b1;
      end
      wr_ptr_q <= wr_ptr_q + AW'(wr_cnt_i);
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_next_o;
    end
  end

endmodule

// File: rtl/stage_5_byte_packer.sv
// Packs two variable-length byte sets per cycle into a FIFO and streams them out
// one byte per cycle, tracking frame end, errors and delivered-byte count.
module stage_5_byte_packer
  import s5_pkg::*;
#(
  parameter int unsigned S5_BITSTREAM_WIDTH = S5_BYTE_W,
  parameter int unsigned S5_FIFO_DEPTH      = 32,
  parameter int unsigned S5_ADDR_WIDTH      = 5
) (
  input  logic                          s5_clk,
  input  logic                          s5_reset,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_1,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_2,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_3,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_4,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1_5,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_1,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_2,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_3,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_4,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2_5,
  input  logic [2:0]                    in_carry_flag_1,
  input  logic [2:0]                    in_carry_flag_2,
  input  logic                          in_flag_last,
  input  logic                          out_ready,
  output logic [S5_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          out_stall,
  output logic                          out_done,
  output logic                          out_error,
  output logic [S5_COUNT_W-1:0]         out_byte_count
);

  localparam int unsigned W  = S5_BITSTREAM_WIDTH;
  localparam int unsigned CW = S5_ADDR_WIDTH + 1;

  logic [W-1:0]             set1 [MAX_BYTES_PER_SET];
  logic [W-1:0]             set2 [MAX_BYTES_PER_SET];
  logic [2:0]               n1;
  logic [2:0]               n2;
  logic [S5_LANE_CNT_W-1:0] total;
  logic [S5_LANE_CNT_W-1:0] wr_cnt;
  logic [S5_LANES*W-1:0]    lane_data;
  logic [S5_LANES-1:0]      lane_tag;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            fifo_count_next;
  logic [CW-1:0]            free_space;
  logic                     head_tag;
  logic                     active;
  logic                     fits;
  logic                     last_acc;
  logic                     tag_prev;
  logic                     done_direct;
  logic                     err_set;
  logic                     pop;

  s5_state_e                state_q;
  logic                     done_q;
  logic                     error_q;
  logic                     stall_q;
  logic [S5_COUNT_W-1:0]    byte_cnt_q;

  assign set1[0] = in_carry_bit_1_1;
  assign set1[1] = in_carry_bit_1_2;
  assign set1[2] = in_carry_bit_1_3;
  assign set1[3] = in_carry_bit_1_4;
  assign set1[4] = in_carry_bit_1_5;
  assign set2[0] = in_carry_bit_2_1;
  assign set2[1] = in_carry_bit_2_2;
  assign set2[2] = in_carry_bit_2_3;
  assign set2[3] = in_carry_bit_2_4;
  assign set2[4] = in_carry_bit_2_5;

  assign out_valid = (fifo_count != '0);
  assign out_last  = out_valid && head_tag;
  assign pop       = out_valid && out_ready;

  // Write admission, frame-end handling and error detection.
  always_comb begin
    n1          = s5_flag_count(in_carry_flag_1);
    n2          = s5_flag_count(in_carry_flag_2);
    total       = S5_LANE_CNT_W'(n1) + S5_LANE_CNT_W'(n2);
    active      = (state_q == S5_IDLE) || (state_q == S5_STREAM);
    free_space  = CW'(S5_FIFO_DEPTH) - fifo_count;
    fits        = free_space >= CW'(total);
    wr_cnt      = (active && fits) ? total : '0;
    last_acc    = active && in_flag_last && fits;
    done_direct = last_acc && (total == '0) &&
                  ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));
    tag_prev    = last_acc && (total == '0) && (fifo_count != '0) && !done_direct;
    err_set     = s5_flag_bad(in_carry_flag_1) || s5_flag_bad(in_carry_flag_2) ||
                  (active && !fits) ||
                  (!active && ((in_carry_flag_1 != '0) || (in_carry_flag_2 != '0)));
  end

  // Compact set 1 then set 2 into contiguous write lanes.
  always_comb begin
    lane_data = '0;
    lane_tag  = '0;
    for (int i = 0; i < int'(MAX_BYTES_PER_SET); i++) begin
      if (i < int'(n1)) begin
        lane_data[i*W +: W] = set1[i];
      end
    end
    for (int i = 0; i < int'(MAX_BYTES_PER_SET); i++) begin
      if (i < int'(n2)) begin
        lane_data[(int'(n1) + i)*W +: W] = set2[i];
      end
    end
    for (int k = 0; k < int'(S5_LANES); k++) begin
      lane_tag[k] = last_acc && (k == int'(total) - 1);
    end
  end

  s5_byte_fifo #(
    .W     (W),
    .DEPTH (S5_FIFO_DEPTH),
    .AW    (S5_ADDR_WIDTH)
  ) u_fifo (
    .clk          (s5_clk),
    .reset        (s5_reset),
    .wr_data_i    (lane_data),
    .wr_tag_i     (lane_tag),
    .wr_cnt_i     (wr_cnt),
    .tag_prev_i   (tag_prev),
    .rd_i         (pop),
    .rd_data_o    (out_byte),
    .rd_tag_o     (head_tag),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next)
  );

  // Frame FSM with registered status outputs.
  always_ff @(posedge s5_clk) begin
    if (s5_reset) begin
      state_q    <= S5_IDLE;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      stall_q    <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      done_q  <= 1'b0;
      stall_q <= (CW'(S5_FIFO_DEPTH) - fifo_count_next) < CW'(STALL_THRESHOLD);
      if (err_set) begin
        error_q <= 1'b1;
      end
      if (pop) begin
        byte_cnt_q <= byte_cnt_q + S5_COUNT_W'(1);
      end
      case (state_q)
        S5_IDLE, S5_STREAM: begin
          if (last_acc) begin
            if (done_direct) begin
              state_q <= S5_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S5_DRAIN;
            end
          end else if ((state_q == S5_IDLE) && (wr_cnt != '0)) begin
            state_q <= S5_STREAM;
          end
        end
        S5_DRAIN: begin
          if (pop && head_tag) begin
            state_q <= S5_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S5_DONE;
      endcase
    end
  end

  assign out_done       = done_q;
  assign out_error      = error_q;
  assign out_stall      = stall_q;
  assign out_byte_count = byte_cnt_q;

endmodule

// File: doc/stage_5_byte_packer.md
STAGE_5_BYTE_PACKER -- requirements
Module: stage_5_byte_packer

Interface
REQ-001 Parameter S5_BITSTREAM_WIDTH, default 8, byte width.
REQ-002 Parameter S5_FIFO_DEPTH, default 32, FIFO entries; power of two, minimum 16.
REQ-003 Parameter S5_ADDR_WIDTH, default 5, log2(S5_FIFO_DEPTH).
REQ-004 s5_clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 s5_reset  in  1  synchronous, active-high reset.
REQ-006 in_carry_bit_1_1..in_carry_bit_1_5  in  8 each  byte set 1, index 1 oldest.
REQ-007 in_carry_bit_2_1..in_carry_bit_2_5  in  8 each  byte set 2, index 1 oldest.
REQ-008 in_carry_flag_1, in_carry_flag_2  in  3 each  count of valid bytes (0..5) in sets 1 and 2.
REQ-009 in_flag_last  in  1  bytes presented this cycle are the final bytes of the frame.
REQ-010 out_ready  in  1  downstream accepts out_byte this cycle.
REQ-011 out_byte  out  8  FIFO head byte.
REQ-012 out_valid  out  1  out_byte is valid.
REQ-013 out_last  out  1  out_byte is the final byte of the frame.
REQ-014 out_stall  out  1  backpressure to the upstream stage.
REQ-015 out_done  out  1  one-cycle pulse when the frame is fully drained.
REQ-016 out_error  out  1  sticky error.
REQ-017 out_byte_count  out  32  bytes delivered since reset.

Function
REQ-018 The block SHALL write set 1 bytes (1..flag_1) and then set 2 bytes (1..flag_2) into the FIFO in order in one cycle.
REQ-019 A flag value of 6 or 7 SHALL be treated as 0 and SHALL set out_error.
REQ-020 The write SHALL occur only if the free space is at least flag_1+flag_2; otherwise all bytes for that cycle SHALL be dropped and out_error set.
REQ-021 Bytes written at edge N SHALL be visible at out_valid/out_byte after edge N (first-word fall-through, 1-cycle latency).
REQ-022 A byte is consumed when out_valid and out_ready are both high; the occupancy update SHALL be count + writes - read for simultaneous write and read.
REQ-023 out_valid SHALL equal (count != 0); out_byte is don't-care when out_valid is low.
REQ-024 out_stall SHALL be high when the free space is below 10, decoded from registered occupancy only.
REQ-025 Read and write pointers SHALL wrap modulo S5_FIFO_DEPTH.
REQ-026 The state machine states are IDLE, STREAM, DRAIN and DONE.
REQ-027 IDLE->STREAM on the first cycle with nonzero total bytes.
REQ-028 IDLE/STREAM->DRAIN on an accepted in_flag_last.
REQ-029 When in_flag_last is accepted, the last byte written that cycle SHALL be tagged as last.
REQ-030 If that cycle writes zero bytes and the FIFO is non-empty, the most recently written entry SHALL be tagged instead.
REQ-031 If that cycle writes zero bytes and the FIFO is empty, the state SHALL go directly to DONE and out_last never asserts.
REQ-032 DRAIN->DONE on the cycle after the tagged byte is consumed.
REQ-033 out_done SHALL pulse for exactly one cycle on entering DONE.
REQ-034 out_last SHALL be high when out_valid is high and the head entry is tagged.
REQ-035 In DRAIN and DONE, nonzero input flags SHALL be ignored and SHALL set out_error.
REQ-036 DONE SHALL be held until reset.
REQ-037 out_byte_count SHALL increment per consumed byte and wrap at 2^32.

Reset
REQ-038 On s5_reset the pointers, occupancy, tags and out_byte_count SHALL clear, state SHALL return to IDLE, and out_valid, out_last, out_done and out_error SHALL be 0.
REQ-039 out_stall SHALL be 0 during and after reset.
REQ-040 Reset mid-frame SHALL discard all buffered bytes with no out_last and no out_done.
REQ-041 FIFO data storage SHALL need no reset.

Structure
REQ-042 Shared package s5_pkg SHALL hold the byte width, MAX_BYTES_PER_SET=5, STALL_THRESHOLD=10 and the state encoding.
REQ-043 Storage and pointer logic SHALL be a sub-module s5_byte_fifo with a 10-write-port-lane input and a single read port.
REQ-044 The top level SHALL contain the lane compaction, the FSM and the counters.

Verification
REQ-045 flag_1=3 (A0,A1,A2), flag_2=2 (B0,B1), out_ready=1 -> out_byte A0,A1,A2,B0,B1 on 5 consecutive cycles starting 1 cycle later; out_byte_count=5.
REQ-046 flag_1=5, flag_2=5 with out_ready=0 for 3 cycles -> 30 bytes stored, out_stall high; a 4th write is dropped and out_error=1.
REQ-047 flag_1=2 with in_flag_last=1, out_ready=1 -> out_last high on the 2nd byte; out_done pulses 1 cycle later; state DONE.
REQ-048 in_flag_last=1 with flags 0 and 4 bytes queued -> out_last on the 4th byte; with an empty FIFO -> out_done the next cycle and out_last never high.
REQ-049 flag_1=7 -> nothing written, out_error=1; s5_reset mid-DRAIN -> out_valid=0, out_byte_count=0, no out_done.
REQ-050 Continuous flag_1=1 writes with out_ready=1 for 100 cycles -> pointers wrap, data in order, occupancy never above 1.
